tsu_vernier_ctrl: RTL



---
 rtl/tsu_pkg.sv | 8 +
 rtl/tsu_gap_mon.sv | 31 +++
 rtl/tsu_vernier_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tsu_pkg.sv
// tsu_pkg: shared states, error codes and default widths for the vernier TSU control slice
package tsu_pkg;
  localparam int DEF_FCLK_DIV_BITS = 3;
  localparam int DEF_RAT_PREC_BITS = 32;
  localparam int DEF_GAP_BITS      = 16;
  typedef enum logic [2:0] {IDLE, FLUSH, ARM, LOCK, RUN, ERR} tsu_ctrl_state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_CFG, ERR_TIMEOUT, ERR_RELOCK} tsu_err_e;
endpackage

// File: rtl/tsu_gap_mon.sv
// tsu_gap_mon: inter-event gap counter, previous-gap register, regularity compare and timeout flag
module tsu_gap_mon import tsu_pkg::*; #(
  parameter int GAP_BITS = DEF_GAP_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                evt_i,
  input  logic [GAP_BITS-1:0] timeout_i,
  output logic                regular_o,
  output logic                timeout_o
);
  logic [GAP_BITS-1:0] gap_q, prev_q, gap_cur, diff;
  // gap_cur is the gap as it stands including this cycle, so an event every N cycles measures N
  always_comb begin
    gap_cur   = &gap_q ? gap_q : gap_q + 1'b1;
    diff      = gap_cur >= prev_q ? gap_cur - prev_q : prev_q - gap_cur;
    regular_o = diff <= GAP_BITS'(1);
    timeout_o = timeout_i != '0 && gap_cur == timeout_i;
  end
  // gap restarts on every event and on lock entry; previous gap captured on each event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q  <= '0;
      prev_q <= '0;
    end else begin
      gap_q <= (clr_i || evt_i) ? '0 : gap_cur;
      if (evt_i) prev_q <= gap_cur;
    end
  end
endmodule

// File: rtl/tsu_vernier_ctrl.sv
// tsu_vernier_ctrl: start/flush/arm/lock/monitor sequencer for the vernier TSU; TSU_VERNIER_CTRL_RELOCK_LIMIT_EN enables the relock counter and its error
module tsu_vernier_ctrl import tsu_pkg::*; #(
  parameter int FCLK_DIV_BITS = DEF_FCLK_DIV_BITS,
  parameter int RAT_PREC_BITS = DEF_RAT_PREC_BITS,
  parameter int GAP_BITS      = DEF_GAP_BITS,
  parameter int FLUSH_CYCS    = 8,
  parameter int LOCK_EVTS     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cfg_valid,
  input  logic [FCLK_DIV_BITS-1:0] i_fclk_div,
  input  logic [RAT_PREC_BITS-1:0] i_num,
  input  logic [RAT_PREC_BITS-1:0] i_denom,
  input  logic [GAP_BITS-1:0]      i_evt_timeout,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_evt,
  output logic [FCLK_DIV_BITS-1:0] o_cfg_fclk_div,
  output logic [RAT_PREC_BITS-1:0] o_cfg_num,
  output logic [RAT_PREC_BITS-1:0] o_cfg_denom,
  output logic                     o_dp_rst_n,
  output logic                     o_vernier_start,
  output logic                     o_vernier_ready,
  output logic                     o_vernier_error,
  output logic [1:0]               o_err_code,
  output logic [7:0]               o_relock_cnt
);
  localparam int FW = $clog2(FLUSH_CYCS + 1);
  localparam int LW = $clog2(LOCK_EVTS + 1);
  tsu_ctrl_state_e          state_q;
  tsu_err_e                 err_code_q;
  logic [FCLK_DIV_BITS-1:0] div_q;
  logic [RAT_PREC_BITS-1:0] num_q, denom_q;
  logic [FW-1:0]            flush_cnt_q;
  logic [LW-1:0]            lock_cnt_q, lock_cnt_d;
  logic                     first_q, dp_rst_n_q, vstart_q, ready_q, error_q;
  logic                     cfg_legal, trk, evt_act, regular, timeout;
`ifdef TSU_VERNIER_CTRL_RELOCK_LIMIT_EN
  logic [7:0]               relock_q;
`endif
  // legality of the shadowed config and event qualification for the tracking states
  always_comb begin
    cfg_legal  = (div_q == FCLK_DIV_BITS'(1) || (div_q != '0 && !div_q[0])) && num_q != '0 && denom_q != '0;
    trk        = state_q == LOCK || state_q == RUN;
    evt_act    = i_evt && trk;
    lock_cnt_d = lock_cnt_q + 1'b1;
  end
  tsu_gap_mon #(.GAP_BITS(GAP_BITS)) u_gap_mon (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == ARM),
    .evt_i     (evt_act),
    .timeout_i (i_evt_timeout),
    .regular_o (regular),
    .timeout_o (timeout)
  );
  // sequencer with every output registered alongside its state transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      err_code_q  <= ERR_NONE;
      div_q       <= '0;
      num_q       <= '0;
      denom_q     <= '0;
      flush_cnt_q <= '0;
      lock_cnt_q  <= '0;
      first_q     <= 1'b0;
      dp_rst_n_q  <= 1'b0;
      vstart_q    <= 1'b0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
`ifdef TSU_VERNIER_CTRL_RELOCK_LIMIT_EN
      relock_q    <= '0;
`endif
    end else begin
      vstart_q <= 1'b0;
      if (i_cfg_valid && (state_q == IDLE || state_q == ERR)) begin
        div_q   <= i_fclk_div;
        num_q   <= i_num;
        denom_q <= i_denom;
      end
      if (i_stop) begin
        state_q    <= IDLE;
        dp_rst_n_q <= 1'b0;
        ready_q    <= 1'b0;
        error_q    <= 1'b0;
        err_code_q <= ERR_NONE;
      end else begin
        case (state_q)
          IDLE, ERR: if (i_start) begin
            state_q     <= cfg_legal ? FLUSH : ERR;
            error_q     <= !cfg_legal;
            err_code_q  <= cfg_legal ? ERR_NONE : ERR_CFG;
            flush_cnt_q <= '0;
          end
          FLUSH: begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
            if (flush_cnt_q == FW'(FLUSH_CYCS - 1)) begin
              state_q    <= ARM;
              dp_rst_n_q <= 1'b1;
              vstart_q   <= 1'b1;
`ifdef TSU_VERNIER_CTRL_RELOCK_LIMIT_EN
              relock_q   <= '0;
`endif
            end
          end
          ARM: begin
            state_q    <= LOCK;
            lock_cnt_q <= '0;
            first_q    <= 1'b1;
          end
          LOCK, RUN: if (timeout) begin
            state_q    <= ERR;
            error_q    <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            dp_rst_n_q <= 1'b0;
            ready_q    <= 1'b0;
          end else if (evt_act && state_q == LOCK) begin
            if (first_q) first_q <= 1'b0;
            else if (regular) begin
              lock_cnt_q <= lock_cnt_d;
              if (lock_cnt_d == LW'(LOCK_EVTS)) begin
                state_q <= RUN;
                ready_q <= 1'b1;
              end
            end else begin
              lock_cnt_q <= LW'(1);
`ifdef TSU_VERNIER_CTRL_RELOCK_LIMIT_EN
              relock_q <= relock_q + {7'd0, ~&relock_q};
              if (relock_q == 8'hFE) begin
                state_q    <= ERR;
                error_q    <= 1'b1;
                err_code_q <= ERR_RELOCK;
                dp_rst_n_q <= 1'b0;
              end
`endif
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign o_cfg_fclk_div  = div_q;
  assign o_cfg_num       = num_q;
  assign o_cfg_denom     = denom_q;
  assign o_dp_rst_n      = dp_rst_n_q;
  assign o_vernier_start = vstart_q;
  assign o_vernier_ready = ready_q;
  assign o_vernier_error = error_q;
  assign o_err_code      = err_code_q;
`ifdef TSU_VERNIER_CTRL_RELOCK_LIMIT_EN
  assign o_relock_cnt    = relock_q;
`else
  assign o_relock_cnt    = '0;
`endif
endmodule
